// File: rtl/flash_writer.sv
// SPI NOR programming engine: WREN, optional 4 KiB sector erase, page program,
// with status polling after each erase/program until the device reports not busy.
module flash_writer #(
    parameter int          MEMORY_LENGTH = 4,
    parameter int          CS_GAP        = 4,
    parameter logic [31:0] POLL_MAX      = 32'd1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       erase,
    input  logic [23:0]                address,
    input  logic [MEMORY_LENGTH*8-1:0] dataBuffer,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [7:0]                 status,
    output logic                       flashClk,
    output logic                       flashMosi,
    output logic                       flashCs,
    input  logic                       flashMiso,
    output logic [3:0]                 o_dbg_state
);

    localparam int SHIFT_W = 32 + 8 * MEMORY_LENGTH;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WREN, S_ERASE, S_PROGRAM, S_POLL,
        S_SEND, S_SEND_HI, S_READ, S_READ_HI, S_TAIL, S_CSUP, S_GAP, S_FINISH
    } state_t;

    state_t                     r_state;
    state_t                     r_op;
    state_t                     r_next;
    logic                       r_erase_phase;
    logic [23:0]                r_addr;
    logic [MEMORY_LENGTH*8-1:0] r_data;
    logic [SHIFT_W-1:0]         r_shift;
    logic [CNT_W-1:0]           r_bits;
    logic [7:0]                 r_rx;
    logic [31:0]                r_poll_cnt;
    logic [GAP_W-1:0]           r_gap;
    logic                       r_fail;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_error;
    logic [7:0]                 r_status;
    logic                       r_clk;
    logic                       r_mosi;
    logic                       r_cs;

    logic [MEMORY_LENGTH*8-1:0] w_payload;
    logic [SHIFT_W-1:0]         w_prog_frame;
    logic [8:0]                 w_page_sum;

    // Byte 0 of the buffer goes on the wire first, so it lands in the top byte.
    always_comb begin
        w_payload = '0;
        for (int n = 0; n < MEMORY_LENGTH; n++) begin
            w_payload[(MEMORY_LENGTH-1-n)*8 +: 8] = r_data[n*8 +: 8];
        end
    end

    assign w_prog_frame = {8'h02, r_addr, w_payload};
    assign w_page_sum   = {1'b0, r_addr[7:0]} + 9'(MEMORY_LENGTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= S_IDLE;
            r_next        <= S_IDLE;
            r_erase_phase <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_shift       <= '0;
            r_bits        <= '0;
            r_rx          <= '0;
            r_poll_cnt    <= '0;
            r_gap         <= '0;
            r_fail        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_status      <= '0;
            r_clk         <= 1'b0;
            r_mosi        <= 1'b0;
            r_cs          <= 1'b1;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr        <= address;
                        r_data        <= dataBuffer;
                        r_erase_phase <= erase;
                        r_fail        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_page_sum > 9'd256) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Guarantee the CS-high gap even right after a previous request.
                        r_gap   <= GAP_W'(CS_GAP - 2);
                        r_next  <= S_WREN;
                        r_state <= S_GAP;
                    end
                end
                S_WREN: begin
                    r_cs    <= 1'b0;
                    r_op    <= S_WREN;
                    r_shift <= {8'h06, {(SHIFT_W-8){1'b0}}};
                    r_bits  <= CNT_W'(8);
                    r_state <= S_SEND;
                end
                S_ERASE: begin
                    r_cs    <= 1'b0;
                    r_op    <= S_ERASE;
                    r_shift <= {8'h20, r_addr, {(SHIFT_W-32){1'b0}}};
                    r_bits  <= CNT_W'(32);
                    r_state <= S_SEND;
                end
                S_PROGRAM: begin
                    r_cs    <= 1'b0;
                    r_op    <= S_PROGRAM;
                    r_shift <= w_prog_frame;
                    r_bits  <= CNT_W'(SHIFT_W);
                    r_state <= S_SEND;
                end
                S_POLL: begin
                    r_cs    <= 1'b0;
                    r_op    <= S_POLL;
                    r_shift <= {8'h05, {(SHIFT_W-8){1'b0}}};
                    r_bits  <= CNT_W'(8);
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    r_clk   <= 1'b0;
                    r_mosi  <= r_shift[SHIFT_W-1];
                    r_shift <= {r_shift[SHIFT_W-2:0], 1'b0};
                    r_bits  <= r_bits - CNT_W'(1);
                    r_state <= S_SEND_HI;
                end
                S_SEND_HI: begin
                    r_clk <= 1'b1;
                    if (r_bits == '0) begin
                        if (r_op == S_POLL) begin
                            r_bits  <= CNT_W'(8);
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_TAIL;
                        end
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                S_READ: begin
                    r_clk   <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_bits  <= r_bits - CNT_W'(1);
                    r_state <= S_READ_HI;
                end
                S_READ_HI: begin
                    r_clk   <= 1'b1;
                    r_rx    <= {r_rx[6:0], flashMiso};
                    r_state <= (r_bits == '0) ? S_TAIL : S_READ;
                end
                S_TAIL: begin
                    r_clk   <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_state <= S_CSUP;
                end
                S_CSUP: begin
                    r_cs    <= 1'b1;
                    r_gap   <= GAP_W'(CS_GAP - 2);
                    r_state <= S_GAP;
                    case (r_op)
                        S_WREN: r_next <= r_erase_phase ? S_ERASE : S_PROGRAM;
                        S_ERASE, S_PROGRAM: begin
                            r_poll_cnt <= '0;
                            r_next     <= S_POLL;
                        end
                        default: begin
                            r_status <= r_rx;
                            if (r_rx[0]) begin
                                if (r_poll_cnt == POLL_MAX - 32'd1) begin
                                    r_fail  <= 1'b1;
                                    r_state <= S_FINISH;
                                end else begin
                                    r_poll_cnt <= r_poll_cnt + 32'd1;
                                    r_next     <= S_POLL;
                                end
                            end else if (r_erase_phase) begin
                                r_erase_phase <= 1'b0;
                                r_next        <= S_WREN;
                            end else begin
                                r_state <= S_FINISH;
                            end
                        end
                    endcase
                end
                S_GAP: begin
                    if (r_gap == '0) r_state <= r_next;
                    else             r_gap   <= r_gap - GAP_W'(1);
                end
                S_FINISH: begin
                    r_done  <= ~r_fail;
                    r_error <= r_fail;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign status      = r_status;
    assign flashClk    = r_clk;
    assign flashMosi   = r_mosi;
    assign flashCs     = r_cs;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer: a behavioural SPI flash model on a muxed bus,
// two DUTs (long poll limit and POLL_MAX=3), byte scoreboard and bus-rule monitors.
module tb_flash_writer;
  localparam int ML     = 4;
  localparam int CS_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_start = 1'b0;
  logic        sel = 1'b0;
  logic        erase = 1'b0;
  logic [23:0] address = '0;
  logic [31:0] data = '0;
  logic        miso = 1'b0;

  logic       busy0, done0, err0, fclk0, mosi0, cs0;
  logic       busy1, done1, err1, fclk1, mosi1, cs1;
  logic [7:0] stat0, stat1;
  logic [3:0] dbg0, dbg1;

  always #5 clk = ~clk;

  flash_writer #(.MEMORY_LENGTH(ML), .CS_GAP(CS_GAP), .POLL_MAX(32'd16)) u_dut (
    .clk(clk), .rst(rst), .start(r_start & ~sel), .erase(erase), .address(address),
    .dataBuffer(data), .busy(busy0), .done(done0), .error(err0), .status(stat0),
    .flashClk(fclk0), .flashMosi(mosi0), .flashCs(cs0), .flashMiso(miso), .o_dbg_state(dbg0));

  flash_writer #(.MEMORY_LENGTH(ML), .CS_GAP(CS_GAP), .POLL_MAX(32'd3)) u_dut_to (
    .clk(clk), .rst(rst), .start(r_start & sel), .erase(erase), .address(address),
    .dataBuffer(data), .busy(busy1), .done(done1), .error(err1), .status(stat1),
    .flashClk(fclk1), .flashMosi(mosi1), .flashCs(cs1), .flashMiso(miso), .o_dbg_state(dbg1));

  logic       m_busy, m_done, m_err, m_clk, m_mosi, m_cs;
  logic [7:0] m_stat;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_err  = sel ? err1  : err0;
  assign m_clk  = sel ? fclk1 : fclk0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_cs   = sel ? cs1   : cs0;
  assign m_stat = sel ? stat1 : stat0;

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_rd = 0;
  int         n_chk = 0, n_pass = 0, n_fail = 0;

  // status script written by the stimulus, read by the flash model
  logic [7:0] stat_arr [4];
  int         stat_len = 0, stat_start = 0;
  logic [7:0] stat_dflt = 8'h00;

  // flash model state
  logic [7:0] sh = '0, cmd = '0, cur_status = '0;
  int         bitcnt = 0, n_polls = 0, seen_id = 0;

  // bus monitor state
  int   cyc = 0, txn_id = 0, lowcnt = 0, highcnt = 1000, last_gap = 0;
  int   n_cs_fall = 0, n_done = 0, n_err = 0, rise_cyc = 0, done_cyc = 0;
  int   n_gap_bad = 0, n_mosi_bad = 0, n_clk_bad = 0;
  int   len_wren = 0, len_erase = 0, len_prog = 0, len_poll = 0;
  logic cs_low_prev = 1'b0, mosi_neg = 1'b0;

  always @(negedge clk) begin
    cyc++;
    mosi_neg = m_mosi;
    if (m_cs === 1'b1) begin
      if (cs_low_prev) begin
        rise_cyc = cyc;
        case (cmd)
          8'h06: len_wren = lowcnt;
          8'h20: len_erase = lowcnt;
          8'h02: len_prog = lowcnt;
          8'h05: len_poll = lowcnt;
          default: ;
        endcase
      end
      highcnt++;
      cs_low_prev = 1'b0;
      if (m_clk !== 1'b0) n_clk_bad++;
    end else if (m_cs === 1'b0) begin
      if (!cs_low_prev) begin
        n_cs_fall++;
        txn_id++;
        if (highcnt < CS_GAP) n_gap_bad++;
        last_gap = highcnt;
        lowcnt = 0;
        highcnt = 0;
      end
      lowcnt++;
      cs_low_prev = 1'b1;
    end
    if (m_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (m_err === 1'b1) n_err++;
  end

  always @(posedge m_clk) begin
    if (m_cs === 1'b0) begin
      if (seen_id != txn_id) begin seen_id = txn_id; bitcnt = 0; cmd = '0; end
      if (m_mosi !== mosi_neg) n_mosi_bad++;
      sh = {sh[6:0], m_mosi};
      bitcnt++;
      if (bitcnt % 8 == 0) begin
        if (bitcnt == 8) begin
          cmd = sh;
          if (sh == 8'h05) begin
            cur_status = (n_polls - stat_start < stat_len) ? stat_arr[n_polls - stat_start] : stat_dflt;
            n_polls++;
          end
        end
        if (bitcnt == 8 || cmd != 8'h05) obs_q.push_back(sh);
      end
    end
  end

  // Device shifts status out on falling SCK, MSB first, after the 8-bit opcode.
  always @(negedge m_clk) begin
    if (m_cs === 1'b0 && cmd == 8'h05 && bitcnt >= 8 && bitcnt <= 15) miso = cur_status[15 - bitcnt];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic e, input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    erase = e; address = a; data = d; r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
  endtask

  task automatic exp_prog(input logic [23:0] a, input logic [31:0] d);
    exp_q.push_back(8'h02);
    exp_q.push_back(a[23:16]); exp_q.push_back(a[15:8]); exp_q.push_back(a[7:0]);
    for (int i = 0; i < ML; i++) exp_q.push_back(d[i*8 +: 8]);
  endtask

  task automatic wait_end(input string tag, input int max);
    int k;
    k = 0;
    while (!(m_done === 1'b1 || m_err === 1'b1) && k < max) begin @(negedge clk); k++; end
    chk({tag, "_finished"}, (k < max) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  task automatic cmp_bytes(input string tag);
    int n;
    n = obs_q.size() - obs_rd;
    chk({tag, "_nbytes"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), obs_q[obs_rd + i], exp_q[i]);
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    int d0, e0, p0, f0, k;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cs", cs0, 1);  chk("rst_clk", fclk0, 0); chk("rst_mosi", mosi0, 0);
    chk("rst_busy", busy0, 0); chk("rst_done", done0, 0); chk("rst_error", err0, 0);
    chk("rst_status", stat0, 8'h00); chk("rst_cs_to", cs1, 1); chk("rst_busy_to", busy1, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: program without erase, device never busy; second start mid-run must be ignored
    stat_start = n_polls; stat_len = 0; stat_dflt = 8'h00;
    d0 = n_done; e0 = n_err; p0 = n_polls;
    pulse_start(1'b0, 24'h000100, 32'h44332211);
    chk("t1_busy", m_busy, 1);
    repeat (40) @(negedge clk);
    pulse_start(1'b1, 24'h0000FE, 32'hDEADBEEF);
    wait_end("t1", 2000);
    exp_q.push_back(8'h06); exp_prog(24'h000100, 32'h44332211); exp_q.push_back(8'h05);
    cmp_bytes("t1");
    chk("t1_done_cnt", n_done - d0, 1); chk("t1_err_cnt", n_err - e0, 0);
    chk("t1_polls", n_polls - p0, 1);   chk("t1_status", m_stat, 8'h00);
    chk("t1_busy_end", m_busy, 0);      chk("t1_cs_end", m_cs, 1);
    chk("t1_len_wren", len_wren, 18);   chk("t1_len_prog", len_prog, 130);
    chk("t1_len_poll", len_poll, 34);   chk("t1_gap_exact", last_gap, CS_GAP);
    chk("t1_done_after_rise", done_cyc - rise_cyc, 1);
    repeat (20) @(negedge clk);
    chk("t1_ignored_start", n_cs_fall > 0 && m_busy === 1'b0 ? 1 : 0, 1);

    // 2: erase + program, device busy for three erase polls
    stat_arr[0] = 8'h03; stat_arr[1] = 8'h03; stat_arr[2] = 8'h03; stat_arr[3] = 8'h00;
    stat_start = n_polls; stat_len = 4; stat_dflt = 8'h00;
    d0 = n_done; e0 = n_err; p0 = n_polls;
    pulse_start(1'b1, 24'h012345, 32'hDDCCBBAA);
    wait_end("t2", 4000);
    exp_q.push_back(8'h06);
    exp_q.push_back(8'h20); exp_q.push_back(8'h01); exp_q.push_back(8'h23); exp_q.push_back(8'h45);
    repeat (4) exp_q.push_back(8'h05);
    exp_q.push_back(8'h06); exp_prog(24'h012345, 32'hDDCCBBAA); exp_q.push_back(8'h05);
    cmp_bytes("t2");
    chk("t2_done_cnt", n_done - d0, 1); chk("t2_err_cnt", n_err - e0, 0);
    chk("t2_polls", n_polls - p0, 5);   chk("t2_status", m_stat, 8'h00);
    chk("t2_len_erase", len_erase, 66);
    repeat (10) @(negedge clk);

    // 3: page crossing is rejected without touching the bus
    d0 = n_done; e0 = n_err; f0 = n_cs_fall;
    pulse_start(1'b0, 24'h0000FE, 32'h01020304);
    k = 0;
    while (m_err !== 1'b1 && k < 4) begin @(negedge clk); k++; end
    chk("t3_err_within2", (k >= 1 && k <= 2) ? 1 : 0, 1);
    repeat (30) @(negedge clk);
    chk("t3_err_cnt", n_err - e0, 1); chk("t3_done_cnt", n_done - d0, 0);
    chk("t3_no_cs_fall", n_cs_fall - f0, 0); chk("t3_busy", m_busy, 0);
    cmp_bytes("t3");

    // 4: poll timeout on the POLL_MAX=3 instance
    sel = 1'b1;
    stat_start = n_polls; stat_len = 0; stat_dflt = 8'h01;
    d0 = n_done; e0 = n_err; p0 = n_polls;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 24'h000010, 32'h00000000);
    wait_end("t4", 3000);
    exp_q.push_back(8'h06); exp_prog(24'h000010, 32'h00000000);
    repeat (3) exp_q.push_back(8'h05);
    cmp_bytes("t4");
    chk("t4_polls", n_polls - p0, 3); chk("t4_err_cnt", n_err - e0, 1);
    chk("t4_done_cnt", n_done - d0, 0); chk("t4_busy", m_busy, 0);
    chk("t4_cs", m_cs, 1); chk("t4_status", m_stat, 8'h01);
    repeat (5) @(negedge clk);
    sel = 1'b0;
    stat_dflt = 8'h00;
    repeat (5) @(negedge clk);

    // 5: reset in the middle of PROGRAM, then a clean request
    pulse_start(1'b0, 24'h000200, 32'h87654321);
    k = 0;
    while (!(cmd == 8'h02 && bitcnt >= 20) && k < 500) begin @(negedge clk); k++; end
    chk("t5_reach_bit20", (k < 500) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_cs", m_cs, 1); chk("t5_clk", m_clk, 0);
    chk("t5_busy", m_busy, 0); chk("t5_mosi", m_mosi, 0);
    rst = 1'b0;
    obs_rd = obs_q.size();
    exp_q.delete();
    repeat (3) @(negedge clk);
    stat_start = n_polls; stat_len = 0;
    d0 = n_done; e0 = n_err;
    pulse_start(1'b0, 24'h000300, 32'h0F1E2D3C);
    wait_end("t5", 2000);
    exp_q.push_back(8'h06); exp_prog(24'h000300, 32'h0F1E2D3C); exp_q.push_back(8'h05);
    cmp_bytes("t5");
    chk("t5_done_cnt", n_done - d0, 1); chk("t5_err_cnt", n_err - e0, 0);
    chk("t5_len_prog", len_prog, 130);

    // bus rules over the whole run
    chk("all_cs_gap_viol", n_gap_bad, 0);
    chk("all_mosi_unstable", n_mosi_bad, 0);
    chk("all_sck_while_cs_high", n_clk_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
